up_int_ctrl: RTL and testbench

Vectored priority interrupt controller that sequences external interrupt sources onto the single `int` input of the `up` processor. It edge-detects and latches N source requests and gates them with a software-written enable register. It selects the highest-priority enabled pending source and runs a request/acknowledge/end-of-interrupt handshake with the core. Sits between peripheral IRQ lines and `up`, replacing the direct `int` drive.

---
 rtl/up_int_pkg.sv | 13 +
 rtl/up_int_prio.sv | 23 ++
 rtl/up_int_ctrl.sv | 95 +++++++++
 tb/tb_up_int_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/up_int_pkg.sv
// Shared definitions for the up interrupt controller: FSM encoding and default sizing.
package up_int_pkg;

  localparam int UP_INT_N  = 4;
  localparam int UP_INT_VW = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_t;

endpackage

// File: rtl/up_int_prio.sv
// Fixed-priority encoder: the lowest set index wins; valid when any bit is set.
module up_int_prio #(
  parameter int N  = 4,
  parameter int VW = 2
) (
  input  logic [N-1:0]  i_vec,
  output logic [VW-1:0] o_idx,
  output logic          o_vld
);

  always_comb begin
    o_idx = '0;
    // Scan from the top down so the last hit, the lowest index, is kept.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = VW'(i);
      end
    end
  end

  assign o_vld = |i_vec;

endmodule

// File: rtl/up_int_ctrl.sv
// Vectored priority interrupt controller driving the single interrupt input of `up`.
// The request output is int_req because `int` is a reserved word in SystemVerilog.
module up_int_ctrl
  import up_int_pkg::*;
#(
  parameter int N  = UP_INT_N,
  parameter int VW = UP_INT_VW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  irq,
  input  logic          ien_wr,
  input  logic [N-1:0]  ien_wdata,
  output logic [N-1:0]  ien,
  output logic [N-1:0]  pending,
  output logic          int_req,
  output logic [VW-1:0] int_vec,
  input  logic          int_ack,
  input  logic          eoi,
  output logic          busy,
  output state_t        dbg_state
);

  // Handshake: int_req is held high in REQ until a one-cycle int_ack is
  // sampled; the core then signals completion with a one-cycle eoi in SVC.
  // int_ack outside REQ and eoi outside SVC are ignored.

  state_t        r_state;
  state_t        w_next;
  logic [N-1:0]  r_irq_q;
  logic [N-1:0]  r_pending;
  logic [N-1:0]  r_ien;
  logic          r_int;
  logic [VW-1:0] r_int_vec;

  logic [N-1:0]  w_edge;
  logic [N-1:0]  w_clr;
  logic          w_ack_ok;
  logic [VW-1:0] w_win;
  logic          w_win_vld;

  assign w_edge   = irq & ~r_irq_q;
  assign w_ack_ok = (r_state == ST_REQ) && int_ack;
  assign w_clr    = w_ack_ok ? (N'(1) << r_int_vec) : '0;

  up_int_prio #(
    .N  (N),
    .VW (VW)
  ) u_prio (
    .i_vec (r_pending & r_ien),
    .o_idx (w_win),
    .o_vld (w_win_vld)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_win_vld) w_next = ST_REQ;
      ST_REQ:  if (int_ack)   w_next = ST_SVC;
      ST_SVC:  if (eoi)       w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_irq_q   <= '0;
      r_pending <= '0;
      r_ien     <= '0;
      r_int     <= 1'b0;
      r_int_vec <= '0;
    end else begin
      r_state   <= w_next;
      r_irq_q   <= irq;
      // A fresh edge on the bit being acknowledged must survive the clear.
      r_pending <= (r_pending & ~w_clr) | w_edge;
      if (ien_wr) begin
        r_ien <= ien_wdata;
      end
      r_int <= (w_next == ST_REQ);
      if ((r_state == ST_IDLE) && w_win_vld) begin
        r_int_vec <= w_win;
      end
    end
  end

  assign ien       = r_ien;
  assign pending   = r_pending;
  assign int_req   = r_int;
  assign int_vec   = r_int_vec;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_up_int_ctrl.sv
// Directed bench for up_int_ctrl: hand-computed expectations for each handshake scenario.
module tb_up_int_ctrl;
  import up_int_pkg::*;

  localparam int N  = 4;
  localparam int VW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq;
  logic          ien_wr;
  logic [N-1:0]  ien_wdata;
  logic [N-1:0]  ien;
  logic [N-1:0]  pending;
  logic          int_req;
  logic [VW-1:0] int_vec;
  logic          int_ack;
  logic          eoi;
  logic          busy;
  state_t        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  up_int_ctrl #(.N(N), .VW(VW)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq       (irq),
    .ien_wr    (ien_wr),
    .ien_wdata (ien_wdata),
    .ien       (ien),
    .pending   (pending),
    .int_req   (int_req),
    .int_vec   (int_vec),
    .int_ack   (int_ack),
    .eoi       (eoi),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // one active edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic write_ien(input logic [N-1:0] v);
    ien_wr = 1'b1;
    ien_wdata = v;
    step();
    ien_wr = 1'b0;
  endtask

  task automatic pulse_irq(input logic [N-1:0] v);
    irq = v;
    step();
    irq = '0;
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    step();
    eoi = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq = '0; ien_wr = 1'b0; ien_wdata = '0; int_ack = 1'b0; eoi = 1'b0;
    step();
    step();
    chk("rst_int",     32'(int_req),   32'd0);
    chk("rst_pending", 32'(pending),   32'd0);
    chk("rst_ien",     32'(ien),       32'd0);
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_vec",     32'(int_vec),   32'd0);
    rst = 1'b0;

    // single source
    write_ien(4'b1111);
    chk("ien_load", 32'(ien), 32'hf);
    pulse_irq(4'b0100);
    chk("single_pend", 32'(pending), 32'b0100);
    chk("single_int_early", 32'(int_req), 32'd0);
    step();
    chk("single_int", 32'(int_req), 32'd1);
    chk("single_vec", 32'(int_vec), 32'd2);
    chk("single_busy", 32'(busy), 32'd1);
    do_ack();
    chk("single_ack_int", 32'(int_req), 32'd0);
    chk("single_ack_pend", 32'(pending), 32'd0);
    chk("single_svc_busy", 32'(busy), 32'd1);
    chk("single_svc_state", 32'(dbg_state), 32'(ST_SVC));
    do_eoi();
    chk("single_eoi_busy", 32'(busy), 32'd0);

    // priority; irq lines held high through ack so a level would re-pend
    irq = 4'b1010;
    step();
    chk("prio_pend", 32'(pending), 32'b1010);
    step();
    chk("prio_int", 32'(int_req), 32'd1);
    chk("prio_vec_first", 32'(int_vec), 32'd1);
    do_ack();
    irq = '0;
    chk("prio_ack_pend", 32'(pending), 32'b1000);
    do_eoi();
    chk("prio_idle", 32'(dbg_state), 32'(ST_IDLE));
    step();
    chk("prio_reint", 32'(int_req), 32'd1);
    chk("prio_vec_second", 32'(int_vec), 32'd3);
    do_ack();
    do_eoi();

    // non-preemption
    pulse_irq(4'b0100);
    step();
    chk("np_vec", 32'(int_vec), 32'd2);
    pulse_irq(4'b0001);
    chk("np_pend", 32'(pending), 32'b0101);
    step();
    chk("np_vec_held", 32'(int_vec), 32'd2);
    chk("np_int_held", 32'(int_req), 32'd1);
    do_ack();
    chk("np_ack_pend", 32'(pending), 32'b0001);
    do_eoi();
    step();
    chk("np_next_int", 32'(int_req), 32'd1);
    chk("np_next_vec", 32'(int_vec), 32'd0);
    do_ack();
    do_eoi();

    // masking
    write_ien(4'b0000);
    pulse_irq(4'b0010);
    chk("mask_pend", 32'(pending), 32'b0010);
    step();
    step();
    chk("mask_int", 32'(int_req), 32'd0);
    chk("mask_busy", 32'(busy), 32'd0);
    write_ien(4'b0010);
    chk("mask_wr_int", 32'(int_req), 32'd0);
    step();
    chk("mask_unmask_int", 32'(int_req), 32'd1);
    chk("mask_unmask_vec", 32'(int_vec), 32'd1);
    do_ack();
    do_eoi();

    // set beats clear, stray handshake inputs
    write_ien(4'b1111);
    pulse_irq(4'b0100);
    step();
    chk("svc_vec", 32'(int_vec), 32'd2);
    irq = 4'b0100;
    int_ack = 1'b1;
    step();
    irq = '0;
    int_ack = 1'b0;
    chk("svc_setwins_pend", 32'(pending), 32'b0100);
    chk("svc_setwins_int", 32'(int_req), 32'd0);
    do_eoi();
    step();
    chk("svc_again_int", 32'(int_req), 32'd1);
    chk("svc_again_vec", 32'(int_vec), 32'd2);
    do_eoi();
    chk("stray_eoi_state", 32'(dbg_state), 32'(ST_REQ));
    chk("stray_eoi_int", 32'(int_req), 32'd1);
    do_ack();
    chk("svc_again_clr", 32'(pending), 32'd0);
    do_eoi();
    do_ack();
    chk("stray_ack_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("stray_ack_int", 32'(int_req), 32'd0);

    // reset mid-REQ
    pulse_irq(4'b0010);
    step();
    chk("pre_rst_int", 32'(int_req), 32'd1);
    chk("pre_rst_pend", 32'(pending), 32'b0010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_int", 32'(int_req), 32'd0);
    chk("mid_rst_pend", 32'(pending), 32'd0);
    chk("mid_rst_ien", 32'(ien), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
